// File: rtl/scene_pkg.sv
// scene_pkg: shared raster timing and scene geometry constants for the
// scene scan generator. Timing values describe 640x480@60 on a 25 MHz clock.
package scene_pkg;

  // Horizontal timing, in pixel clocks
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  // Vertical timing, in lines
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  // Scene ROM geometry (source pixels; the screen shows it at 2x)
  localparam int SCENE_W   = 512;
  localparam int SCENE_H   = 240;
  localparam int SRC_VIS_W = H_VIS / 2;
  localparam int MAX_SCROLL = SCENE_W - SRC_VIS_W;

  // Datapath widths
  localparam int ADDR_W   = 18;
  localparam int CNT_W    = 10;
  localparam int SCROLL_W = 9;

endpackage

// File: rtl/vga_timing_ctr.sv
// vga_timing_ctr: free-running horizontal/vertical raster counters with
// combinational sync, visible-area and line/frame-end decodes.
module vga_timing_ctr #(
  parameter int H_VIS  = scene_pkg::H_VIS,
  parameter int H_FP   = scene_pkg::H_FP,
  parameter int H_SYNC = scene_pkg::H_SYNC,
  parameter int H_BP   = scene_pkg::H_BP,
  parameter int V_VIS  = scene_pkg::V_VIS,
  parameter int V_FP   = scene_pkg::V_FP,
  parameter int V_SYNC = scene_pkg::V_SYNC,
  parameter int V_BP   = scene_pkg::V_BP
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [9:0] o_h_cnt,
  output logic [9:0] o_v_cnt,
  output logic       o_line_end,
  output logic       o_frame_end,
  output logic       o_visible,
  output logic       o_hsync_n,
  output logic       o_vsync_n
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C    = 10'(V_VIS);
  localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       w_line_end;
  logic       w_frame_end;

  assign w_line_end  = (r_h_cnt == H_LAST);
  assign w_frame_end = w_line_end && (r_v_cnt == V_LAST);

  // Raster position: h wraps every line, v advances on each h wrap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_line_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;
  assign o_line_end  = w_line_end;
  assign o_frame_end = w_frame_end;
  assign o_visible   = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
  assign o_hsync_n   = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
  assign o_vsync_n   = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));

endmodule

// File: rtl/scene_scan_gen.sv
// scene_scan_gen: VGA raster timing plus 2x-scaled, horizontally scrolled
// scene ROM addressing for the renderer. Syncs get one extra register stage
// to line up with the renderer's registered RGB.
// Build option: define SCENE_SCROLL_EN to enable the per-frame scroll latch;
// without it scroll_x is ignored and the scroll offset is fixed at 0.
module scene_scan_gen import scene_pkg::*; #(
  parameter int H_VIS  = scene_pkg::H_VIS,
  parameter int H_FP   = scene_pkg::H_FP,
  parameter int H_SYNC = scene_pkg::H_SYNC,
  parameter int H_BP   = scene_pkg::H_BP,
  parameter int V_VIS  = scene_pkg::V_VIS,
  parameter int V_FP   = scene_pkg::V_FP,
  parameter int V_SYNC = scene_pkg::V_SYNC,
  parameter int V_BP   = scene_pkg::V_BP
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [8:0]        scroll_x,
  output logic [ADDR_W-1:0] rom_address,
  output logic              blank,
  output logic              hs_n,
  output logic              vs_n,
  output logic [9:0]        draw_x,
  output logic [9:0]        draw_y,
  output logic              frame_start
);

  localparam logic [9:0] V_VIS_C = 10'(V_VIS);

  logic [9:0]        w_h_cnt;
  logic [9:0]        w_v_cnt;
  logic              w_line_end;
  logic              w_frame_end;
  logic              w_visible;
  logic              w_hsync_n;
  logic              w_vsync_n;
  logic [8:0]        w_scroll_lat;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_rom_address;
  logic              r_blank;
  logic [9:0]        r_draw_x;
  logic [9:0]        r_draw_y;
  logic              r_frame_start;
  logic              r_hs1_n;
  logic              r_vs1_n;
  logic              r_hs_n;
  logic              r_vs_n;

  vga_timing_ctr #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .i_clk       (vga_clk),
    .i_rst_n     (reset_n),
    .o_h_cnt     (w_h_cnt),
    .o_v_cnt     (w_v_cnt),
    .o_line_end  (w_line_end),
    .o_frame_end (w_frame_end),
    .o_visible   (w_visible),
    .o_hsync_n   (w_hsync_n),
    .o_vsync_n   (w_vsync_n)
  );

`ifdef SCENE_SCROLL_EN
  localparam logic [8:0] SCROLL_MAX = 9'(SCENE_W - H_VIS / 2);

  logic [8:0] r_scroll_lat;

  // Sample the requested scroll once, on the last clock of the frame, clamped
  // so the right screen edge never runs past the scene row
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scroll_lat <= '0;
    end else if (w_frame_end) begin
      r_scroll_lat <= (scroll_x > SCROLL_MAX) ? SCROLL_MAX : scroll_x;
    end
  end

  assign w_scroll_lat = r_scroll_lat;
`else
  logic w_unused_scroll;

  assign w_scroll_lat    = '0;
  assign w_unused_scroll = ^scroll_x;
`endif

  // Source row base: each source row covers two screen lines, so step the
  // base one row pitch after every odd visible line instead of multiplying
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row_base <= '0;
    end else if (w_frame_end) begin
      r_row_base <= '0;
    end else if (w_line_end && w_v_cnt[0] && (w_v_cnt < V_VIS_C)) begin
      r_row_base <= r_row_base + ADDR_W'(SCENE_W);
    end
  end

  assign w_addr = r_row_base + ADDR_W'(w_h_cnt[9:1]) + ADDR_W'(w_scroll_lat);

  // Stage 1: address, blank, position and frame marker from the counters
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_address <= '0;
      r_blank       <= 1'b0;
      r_draw_x      <= '0;
      r_draw_y      <= '0;
      r_frame_start <= 1'b0;
      r_hs1_n       <= 1'b1;
      r_vs1_n       <= 1'b1;
    end else begin
      r_rom_address <= w_visible ? w_addr : '0;
      r_blank       <= w_visible;
      r_draw_x      <= w_h_cnt;
      r_draw_y      <= w_v_cnt;
      r_frame_start <= (w_h_cnt == 10'd0) && (w_v_cnt == 10'd0);
      r_hs1_n       <= w_hsync_n;
      r_vs1_n       <= w_vsync_n;
    end
  end

  // Stage 2: syncs wait one more clock for the renderer's RGB register
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_n <= 1'b1;
      r_vs_n <= 1'b1;
    end else begin
      r_hs_n <= r_hs1_n;
      r_vs_n <= r_vs1_n;
    end
  end

  assign rom_address = r_rom_address;
  assign blank       = r_blank;
  assign draw_x      = r_draw_x;
  assign draw_y      = r_draw_y;
  assign frame_start = r_frame_start;
  assign hs_n        = r_hs_n;
  assign vs_n        = r_vs_n;

endmodule

// File: tb/tb_scene_scan_gen.sv
// tb_scene_scan_gen: self-checking bench for scene_scan_gen. Uses full
// horizontal timing and a shortened vertical frame so several frames fit in
// a short run. Expected outputs come from a position-based model: the raster
// position of each clock is derived arithmetically from the clock count.
module tb_scene_scan_gen;

  localparam int H_TOT  = 800;
  localparam int H_VIS  = 640;
  localparam int V_VIS  = 6;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 1;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;

  localparam logic [41:0] RST_VEC = {18'd0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0};

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [8:0]  scroll_x = 9'd0;
  logic [17:0] rom_address;
  logic        blank;
  logic        hs_n;
  logic        vs_n;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        frame_start;
  logic [41:0] obs;

  int total = 0;
  int bad = 0;
  int p_next = 0;
  int cur_p = 0;
  int scroll_frame[32];

  assign obs = {rom_address, blank, hs_n, vs_n, draw_x, draw_y, frame_start};

  scene_scan_gen #(
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .scroll_x    (scroll_x),
    .rom_address (rom_address),
    .blank       (blank),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .frame_start (frame_start)
  );

  always #20 vga_clk = ~vga_clk;

  // Scroll actually applied for a requested value
  function automatic int clamp_scroll(int x);
`ifdef SCENE_SCROLL_EN
    return (x > 192) ? 192 : x;
`else
    return 0 * x;
`endif
  endfunction

  // Expected outputs after the clock whose raster position is p
  function automatic logic [41:0] model_out(int p);
    int hh, vv, ph, pv, a;
    logic bl, hs, vs, fs;
    hh = p % H_TOT;
    vv = (p / H_TOT) % V_TOT;
    bl = (hh < H_VIS) && (vv < V_VIS);
    a  = bl ? ((vv / 2) * 512 + hh / 2 + scroll_frame[(p / FRAME) % 32]) : 0;
    fs = (p % FRAME) == 0;
    if (p == 0) begin
      hs = 1'b1;
      vs = 1'b1;
    end else begin
      ph = (p - 1) % H_TOT;
      pv = ((p - 1) / H_TOT) % V_TOT;
      hs = !(ph >= 656 && ph < 752);
      vs = !(pv >= V_VIS + V_FP && pv < V_VIS + V_FP + V_SYNC);
    end
    return {18'(a), bl, hs, vs, 10'(hh), 10'(vv), fs};
  endfunction

  // One clock: note the position, record any frame-end scroll sample
  task automatic tick();
    @(posedge vga_clk);
    cur_p = p_next;
    if ((cur_p % FRAME) == FRAME - 1)
      scroll_frame[(cur_p / FRAME + 1) % 32] = clamp_scroll(int'(scroll_x));
    p_next++;
    #1;
  endtask

  task automatic release_reset();
    @(negedge vga_clk);
    reset_n = 1'b1;
    p_next = 0;
    for (int i = 0; i < 32; i++) scroll_frame[i] = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    scroll_x = 9'd0;
    repeat (3) @(posedge vga_clk);
    #1;
    total++;
    if (obs !== RST_VEC) begin
      bad++;
      $display("FAIL reset_hold got=%h want=%h", obs, RST_VEC);
    end
    release_reset();
    #1;
    total++;
    if (obs !== RST_VEC) begin
      bad++;
      $display("FAIL reset_release_pre_edge got=%h want=%h", obs, RST_VEC);
    end
    tick();
    total++;
    if (frame_start !== 1'b1 || blank !== 1'b1 || rom_address !== 18'd0) begin
      bad++;
      $display("FAIL first_pixel fs=%b blank=%b addr=%0d want fs=1 blank=1 addr=0",
               frame_start, blank, rom_address);
    end
    total++;
    if (obs !== model_out(cur_p)) begin
      bad++;
      $display("FAIL first_pixel_all got=%h want=%h", obs, model_out(cur_p));
    end
    $display("test_reset: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_line();
    int bl_cnt, hs_low, first_bl, first_hs, next_bl;
    bl_cnt = 0; hs_low = 0; first_bl = -1; first_hs = -1; next_bl = -1;
    while (cur_p < 1600) begin
      tick();
      total++;
      if (obs !== model_out(cur_p)) begin
        bad++;
        $display("FAIL line_px p=%0d got=%h want=%h", cur_p, obs, model_out(cur_p));
      end
      if (cur_p == 2) begin
        total++;
        if (rom_address !== 18'd1) begin
          bad++;
          $display("FAIL addr_x2_y0 got=%0d want=1", rom_address);
        end
      end
      if (cur_p >= 800 && cur_p < 1600) begin
        if (blank) begin
          bl_cnt++;
          if (first_bl < 0) first_bl = cur_p;
        end
        if (!hs_n) begin
          hs_low++;
          if (first_hs < 0) first_hs = cur_p;
        end
      end else if (cur_p == 1600 && blank) begin
        next_bl = cur_p;
      end
    end
    total++;
    if (bl_cnt !== 640) begin
      bad++;
      $display("FAIL line_blank_width got=%0d want=640", bl_cnt);
    end
    total++;
    if (hs_low !== 96) begin
      bad++;
      $display("FAIL hsync_width got=%0d want=96", hs_low);
    end
    total++;
    if (first_hs - first_bl !== 657) begin
      bad++;
      $display("FAIL hsync_offset got=%0d want=657", first_hs - first_bl);
    end
    total++;
    if (next_bl - first_bl !== 800) begin
      bad++;
      $display("FAIL line_period got=%0d want=800", next_bl - first_bl);
    end
    $display("test_line: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_frame();
    int vs_low;
    vs_low = 0;
    scroll_x = 9'd300;
    while (cur_p < FRAME - 1) begin
      tick();
      total++;
      if (obs !== model_out(cur_p)) begin
        bad++;
        $display("FAIL frame_px p=%0d got=%h want=%h", cur_p, obs, model_out(cur_p));
      end
      if (!vs_n) vs_low++;
      if (cur_p == 2 * H_TOT) begin
        total++;
        if (rom_address !== 18'd512) begin
          bad++;
          $display("FAIL addr_x0_y2 got=%0d want=512", rom_address);
        end
      end
      if (cur_p == (V_VIS - 1) * H_TOT + 639) begin
        total++;
        if (rom_address !== 18'(((V_VIS - 1) / 2) * 512 + 319)) begin
          bad++;
          $display("FAIL addr_last_px got=%0d want=%0d", rom_address,
                   ((V_VIS - 1) / 2) * 512 + 319);
        end
      end
    end
    total++;
    if (vs_low !== V_SYNC * H_TOT) begin
      bad++;
      $display("FAIL vsync_width got=%0d want=%0d", vs_low, V_SYNC * H_TOT);
    end
    $display("test_frame: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_scroll_clamp();
    int s;
    s = clamp_scroll(300);
    while (cur_p < 2 * FRAME - 1) begin
      tick();
      total++;
      if (obs !== model_out(cur_p)) begin
        bad++;
        $display("FAIL clamp_px p=%0d got=%h want=%h", cur_p, obs, model_out(cur_p));
      end
      if (cur_p == FRAME) begin
        total++;
        if (rom_address !== 18'(s)) begin
          bad++;
          $display("FAIL clamp_x0 got=%0d want=%0d", rom_address, s);
        end
      end
      if (cur_p == FRAME + 639) begin
        total++;
        if (rom_address !== 18'(319 + s)) begin
          bad++;
          $display("FAIL clamp_x639 got=%0d want=%0d", rom_address, 319 + s);
        end
      end
      if (cur_p == FRAME + 100) scroll_x = 9'd10;
    end
    $display("test_scroll_clamp: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_scroll_midframe();
    while (cur_p < 3 * FRAME) begin
      tick();
      total++;
      if (obs !== model_out(cur_p)) begin
        bad++;
        $display("FAIL midframe_px p=%0d got=%h want=%h", cur_p, obs, model_out(cur_p));
      end
      if (cur_p == 2 * FRAME) begin
        total++;
        if (rom_address !== 18'(clamp_scroll(10))) begin
          bad++;
          $display("FAIL scroll10_origin got=%0d want=%0d", rom_address, clamp_scroll(10));
        end
      end
      if (cur_p == 2 * FRAME + 3000) scroll_x = 9'd50;
      if (cur_p == 2 * FRAME + 4 * H_TOT) begin
        total++;
        if (rom_address !== 18'(1024 + clamp_scroll(10))) begin
          bad++;
          $display("FAIL scroll_held got=%0d want=%0d", rom_address, 1024 + clamp_scroll(10));
        end
      end
      if (cur_p == 3 * FRAME) begin
        total++;
        if (rom_address !== 18'(clamp_scroll(50))) begin
          bad++;
          $display("FAIL scroll50_origin got=%0d want=%0d", rom_address, clamp_scroll(50));
        end
      end
    end
    $display("test_scroll_midframe: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_random_scroll();
    while (cur_p < 5 * FRAME) begin
      tick();
      total++;
      if (obs !== model_out(cur_p)) begin
        bad++;
        $display("FAIL random_px p=%0d scroll=%0d got=%h want=%h", cur_p, scroll_x,
                 obs, model_out(cur_p));
      end
      if ($urandom_range(0, 399) == 0) scroll_x = 9'($urandom_range(0, 511));
    end
    $display("test_random_scroll: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_reset_midline();
    while (cur_p < 5 * FRAME + 3 * H_TOT + 299) tick();
    #5;
    reset_n = 1'b0;
    #1;
    total++;
    if (obs !== RST_VEC) begin
      bad++;
      $display("FAIL async_reset got=%h want=%h", obs, RST_VEC);
    end
    repeat (2) @(posedge vga_clk);
    #1;
    total++;
    if (obs !== RST_VEC) begin
      bad++;
      $display("FAIL reset_held_mid got=%h want=%h", obs, RST_VEC);
    end
    release_reset();
    while (p_next <= 1600) begin
      tick();
      total++;
      if (obs !== model_out(cur_p)) begin
        bad++;
        $display("FAIL restart_px p=%0d got=%h want=%h", cur_p, obs, model_out(cur_p));
      end
      if (cur_p == 0) begin
        total++;
        if (frame_start !== 1'b1 || rom_address !== 18'd0) begin
          bad++;
          $display("FAIL restart_origin fs=%b addr=%0d want fs=1 addr=0",
                   frame_start, rom_address);
        end
      end
      if (cur_p == 2 * H_TOT) begin
        total++;
        if (rom_address !== 18'd512) begin
          bad++;
          $display("FAIL restart_row_base got=%0d want=512", rom_address);
        end
      end
    end
    $display("test_reset_midline: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) scroll_frame[i] = 0;
    test_reset();
    test_line();
    test_frame();
    test_scroll_clamp();
    test_scroll_midframe();
    test_random_scroll();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
